// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit:
// access sizes, branch funct3 codes, FSM states and byte-enable width derivation.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } memSize_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } brFunct3_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    DONE   = 2'b11
  } lsuState_e;

  // One byte-enable bit per byte of the data bus.
  function automatic int beWidth(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store-side byte enables, lane replication and
// misalignment detection; load-side lane extraction with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = beWidth(XLEN)
) (
  input  logic [1:0]               stSize,
  input  logic [2:0]               stAddrLow,
  input  logic [XLEN-1:0]          stData,
  output logic [BE_W-1:0]          stBe,
  output logic [XLEN-1:0]          stWdata,
  output logic                     stMisalign,
  input  logic [1:0]               ldSize,
  input  logic [$clog2(BE_W)-1:0]  ldOff,
  input  logic                     ldUnsigned,
  input  logic [XLEN-1:0]          ldData,
  output logic [XLEN-1:0]          ldResult
);

  localparam int OFF_W = $clog2(BE_W);

  logic [BE_W-1:0] sizeMask;
  logic [XLEN-1:0] ldShifted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    sizeMask   = '0;
    stWdata    = stData;
    stMisalign = 1'b0;
    case (stSize)
      SIZE_B: begin
        sizeMask = BE_W'(1'b1);
        stWdata  = {BE_W{stData[7:0]}};
      end
      SIZE_H: begin
        sizeMask   = BE_W'(2'b11);
        stWdata    = {(BE_W / 2){stData[15:0]}};
        stMisalign = stAddrLow[0];
      end
      SIZE_W: begin
        sizeMask   = BE_W'(4'hF);
        stWdata    = {(XLEN / 32){stData[31:0]}};
        stMisalign = |stAddrLow[1:0];
      end
      default: begin
        // A dword access cannot be served by a 32-bit bus at all.
        sizeMask   = '1;
        stWdata    = stData;
        stMisalign = (XLEN == 32) || (|stAddrLow[2:0]);
      end
    endcase
  end

  assign stBe = sizeMask << stAddrLow[OFF_W-1:0];

  assign ldShifted = ldData >> {ldOff, 3'b000};

  always_comb begin
    ldResult = ldShifted;
    case (ldSize)
      SIZE_B: ldResult = ldUnsigned ? XLEN'(ldShifted[7:0])
                                    : XLEN'($signed(ldShifted[7:0]));
      SIZE_H: ldResult = ldUnsigned ? XLEN'(ldShifted[15:0])
                                    : XLEN'($signed(ldShifted[15:0]));
      SIZE_W: ldResult = ldUnsigned ? XLEN'(ldShifted[31:0])
                                    : XLEN'($signed(ldShifted[31:0]));
      default: ldResult = ldShifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the 5-stage pipeline: branch resolution from ALU flags plus a
// load/store unit on a req/gnt/rvalid data bus, with valid/ready on both sides.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int BE_W   = beWidth(XLEN)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              branch,
  input  logic              jump,
  input  logic [2:0]        br_funct3,
  input  logic              Z,
  input  logic              C,
  input  logic              N,
  input  logic              V,
  input  logic              mem_rd,
  input  logic              mem_wrt,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   rdata,
  output logic              assert_boj,
  output logic              misalign,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [BE_W-1:0]   dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  localparam int OFF_W = $clog2(BE_W);

  lsuState_e        state, nextState;
  logic             accept, brTaken, misNow, toBus;
  logic             bojQ, misQ, isLoadQ, ldUnsQ;
  logic [1:0]       ldSizeQ;
  logic [OFF_W-1:0] ldOffQ;
  logic [BE_W-1:0]  alignBe;
  logic [XLEN-1:0]  alignWdata, alignRdata;
  logic             alignMis;

  mem_align #(
    .XLEN(XLEN),
    .BE_W(BE_W)
  ) uAlign (
    .stSize    (mem_size),
    .stAddrLow (addr[2:0]),
    .stData    (wdata),
    .stBe      (alignBe),
    .stWdata   (alignWdata),
    .stMisalign(alignMis),
    .ldSize    (ldSizeQ),
    .ldOff     (ldOffQ),
    .ldUnsigned(ldUnsQ),
    .ldData    (dmem_rdata),
    .ldResult  (alignRdata)
  );

  always_comb begin
    brTaken = 1'b0;
    case (br_funct3)
      BR_BEQ:  brTaken = Z;
      BR_BNE:  brTaken = ~Z;
      BR_BLT:  brTaken = N ^ V;
      BR_BGE:  brTaken = ~(N ^ V);
      BR_BLTU: brTaken = C;
      BR_BGEU: brTaken = ~C;
      default: brTaken = 1'b0;
    endcase
  end

  assign in_ready = (state == IDLE) && !rst_;
  assign accept   = in_valid && in_ready;
  assign misNow   = (mem_rd || mem_wrt) && alignMis;
  assign toBus    = (mem_rd || mem_wrt) && !alignMis;

  assign out_valid  = (state == DONE);
  assign dmem_req   = (state == REQ);
  assign assert_boj = bojQ && out_valid;
  assign misalign   = misQ && out_valid;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst_) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = toBus ? REQ : DONE;
      REQ:     if (dmem_gnt) nextState = isLoadQ ? WAIT_R : DONE;
      WAIT_R:  if (dmem_rvalid) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      bojQ       <= 1'b0;
      misQ       <= 1'b0;
      isLoadQ    <= 1'b0;
      ldUnsQ     <= 1'b0;
      ldSizeQ    <= '0;
      ldOffQ     <= '0;
      rdata      <= '0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      if (accept) begin
        bojQ    <= (branch && brTaken) || jump;
        misQ    <= misNow;
        isLoadQ <= mem_rd;
        ldUnsQ  <= mem_unsigned;
        ldSizeQ <= mem_size;
        ldOffQ  <= addr[OFF_W-1:0];
        rdata   <= '0;
        if (toBus) begin
          // A combined load+store performs only the load.
          dmem_we    <= mem_wrt && !mem_rd;
          dmem_be    <= alignBe;
          dmem_addr  <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          dmem_wdata <= alignWdata;
        end else begin
          dmem_we    <= 1'b0;
          dmem_be    <= '0;
          dmem_addr  <= '0;
          dmem_wdata <= '0;
        end
      end
      if (state == WAIT_R && dmem_rvalid) rdata <= alignRdata;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a vector table of single ops with bus wait
// states, plus hand sequences for reset values and reset during a load.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_;
  logic        in_valid, in_ready, branch, jump;
  logic [2:0]  br_funct3;
  logic        Z, C, N, V, mem_rd, mem_wrt, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        out_valid, out_ready, assert_boj, misalign;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;

  int passCnt = 0;
  int totalCnt = 0;

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
    .branch(branch), .jump(jump), .br_funct3(br_funct3),
    .Z(Z), .C(C), .N(N), .V(V),
    .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .addr(addr), .wdata(wdata), .out_valid(out_valid), .out_ready(out_ready),
    .rdata(rdata), .assert_boj(assert_boj), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        branch, jump;
    logic [2:0]  f3;
    logic [3:0]  zcnv;
    logic        rd, wrt;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    int          gntWait, rvWait;
    logic [31:0] busRdata;
    int          hold;
    logic        expBoj, expMis, expReq, expWe;
    logic [3:0]  expBe;
    logic [31:0] expAddr, expWdata, expRdata;
    int          expLat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic runOp(input vec_t v);
    int lat, gntCnt, rvCnt;
    bit done, sawReq, waitR;
    @(negedge clk);
    check({v.name, ":in_ready"}, 64'(in_ready), 64'(1));
    branch = v.branch; jump = v.jump; br_funct3 = v.f3;
    {Z, C, N, V} = v.zcnv;
    mem_rd = v.rd; mem_wrt = v.wrt; mem_size = v.size; mem_unsigned = v.uns;
    addr = v.addr; wdata = v.wdata;
    out_ready = (v.hold == 0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; branch = 1'b0; jump = 1'b0; mem_rd = 1'b0; mem_wrt = 1'b0;
    lat = 0; gntCnt = 0; rvCnt = 0; done = 0; sawReq = 0; waitR = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
      if (out_valid) begin
        done = 1;
      end else if (dmem_req) begin
        if (!sawReq) begin
          check({v.name, ":be"}, 64'(dmem_be), 64'(v.expBe));
          check({v.name, ":daddr"}, 64'(dmem_addr), 64'(v.expAddr));
          check({v.name, ":we"}, 64'(dmem_we), 64'(v.expWe));
          if (v.expWe) check({v.name, ":dwdata"}, 64'(dmem_wdata), 64'(v.expWdata));
        end
        sawReq = 1;
        if (gntCnt == v.gntWait) begin
          dmem_gnt = 1'b1;
          waitR = v.rd;
        end else gntCnt++;
      end else if (waitR) begin
        if (rvCnt == v.rvWait) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = v.busRdata;
        end else rvCnt++;
      end
    end
    check({v.name, ":latency"}, 64'(lat), 64'(v.expLat));
    check({v.name, ":req_seen"}, 64'(sawReq), 64'(v.expReq));
    check({v.name, ":boj"}, 64'(assert_boj), 64'(v.expBoj));
    check({v.name, ":misalign"}, 64'(misalign), 64'(v.expMis));
    check({v.name, ":rdata"}, 64'(rdata), 64'(v.expRdata));
    // Stray rvalid while held in DONE must not disturb the result.
    for (int i = 0; i < v.hold; i++) begin
      dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check({v.name, ":hold_valid"}, 64'(out_valid), 64'(1));
      check({v.name, ":hold_in_ready"}, 64'(in_ready), 64'(0));
      check({v.name, ":hold_rdata"}, 64'(rdata), 64'(v.expRdata));
      check({v.name, ":hold_boj"}, 64'(assert_boj), 64'(v.expBoj));
    end
    dmem_rvalid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({v.name, ":idle_valid"}, 64'(out_valid), 64'(0));
    check({v.name, ":idle_in_ready"}, 64'(in_ready), 64'(1));
    check({v.name, ":idle_boj"}, 64'(assert_boj), 64'(0));
    check({v.name, ":idle_mis"}, 64'(misalign), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //               name        br    jmp   f3      ZCNV     rd    wrt   size   uns   addr          wdata         gW rW bus           hold
    //               boj   mis   req   we    be      daddr         dwdata        rdata         lat
    vecs[0]  = '{"bltu_c1",  1'b1, 1'b0, 3'b110, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[1]  = '{"bltu_c0",  1'b1, 1'b0, 3'b110, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[2]  = '{"jump",     1'b0, 1'b1, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[3]  = '{"beq_z1",   1'b1, 1'b0, 3'b000, 4'b1000, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[4]  = '{"bne_z1",   1'b1, 1'b0, 3'b001, 4'b1000, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[5]  = '{"blt_n1",   1'b1, 1'b0, 3'b100, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[6]  = '{"bge_nv",   1'b1, 1'b0, 3'b101, 4'b0011, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[7]  = '{"bgeu_c1",  1'b1, 1'b0, 3'b111, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[8]  = '{"f3_010",   1'b1, 1'b0, 3'b010, 4'b1100, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        0, 0, 32'h0,        0,
                 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[9]  = '{"sb_1003",  1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0,       0,
                 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h0000_1000, 32'hABAB_ABAB, 32'h0,       2};
    vecs[10] = '{"sh_2002",  1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 1, 0, 32'h0,       0,
                 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF, 32'h0,       3};
    vecs[11] = '{"sw_3004",  1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_3004, 32'hDEAD_BEEF, 0, 0, 32'h0,       0,
                 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_3004, 32'hDEAD_BEEF, 32'h0,       2};
    vecs[12] = '{"lh_2002",  1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,        3, 2, 32'h8001_5A5A, 0,
                 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h0000_2000, 32'h0,        32'hFFFF_8001, 8};
    vecs[13] = '{"lhu_2002", 1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        3, 2, 32'h8001_5A5A, 0,
                 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_8001, 8};
    vecs[14] = '{"lb_0101",  1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        0, 0, 32'h1122_F680, 0,
                 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 32'h0000_0100, 32'h0,        32'hFFFF_FFF6, 3};
    vecs[15] = '{"lbu_0103", 1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        0, 0, 32'h9A00_0000, 0,
                 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_009A, 3};
    vecs[16] = '{"lw_mis",   1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,        0, 0, 32'h0,        0,
                 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[17] = '{"sh_mis",   1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h1234_5678, 0, 0, 32'h0,       0,
                 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[18] = '{"ld_mis",   1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,        0, 0, 32'h0,        0,
                 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,   32'h0,        32'h0,        32'h0,        1};
    vecs[19] = '{"lw_hold",  1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        1, 1, 32'hCAFE_F00D, 4,
                 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0040, 32'h0,        32'hCAFE_F00D, 5};
    vecs[20] = '{"rd_wrt",   1'b0, 1'b0, 3'b000, 4'b0000, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 0, 0, 32'h0102_0304, 0,
                 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0010, 32'h0,        32'h0102_0304, 3};
    vecs[21] = '{"blt_sw",   1'b1, 1'b0, 3'b100, 4'b0001, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 0, 0, 32'h0,       0,
                 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_0020, 32'h1122_3344, 32'h0,       2};

    rst_ = 1'b1; in_valid = 1'b0; branch = 1'b0; jump = 1'b0; br_funct3 = 3'b000;
    {Z, C, N, V} = 4'b0000; mem_rd = 1'b0; mem_wrt = 1'b0; mem_size = 2'b00;
    mem_unsigned = 1'b0; addr = '0; wdata = '0; out_ready = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:in_ready", 64'(in_ready), 64'(0));
    check("rst:out_valid", 64'(out_valid), 64'(0));
    check("rst:dmem_req", 64'(dmem_req), 64'(0));
    check("rst:dmem_we", 64'(dmem_we), 64'(0));
    check("rst:dmem_be", 64'(dmem_be), 64'(0));
    check("rst:dmem_addr", 64'(dmem_addr), 64'(0));
    check("rst:dmem_wdata", 64'(dmem_wdata), 64'(0));
    check("rst:rdata", 64'(rdata), 64'(0));
    check("rst:boj", 64'(assert_boj), 64'(0));
    check("rst:misalign", 64'(misalign), 64'(0));
    rst_ = 1'b0;
    @(negedge clk);
    check("post_rst:in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 22; i++) runOp(vecs[i]);

    // Reset while waiting for read data; the late rvalid must be discarded.
    @(negedge clk);
    mem_rd = 1'b1; mem_size = 2'b10; mem_unsigned = 1'b0; addr = 32'h0000_0080;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; mem_rd = 1'b0;
    @(negedge clk);
    check("mid_rst:req", 64'(dmem_req), 64'(1));
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("mid_rst:wait_r_req", 64'(dmem_req), 64'(0));
    rst_ = 1'b1;
    @(negedge clk);
    check("mid_rst:req_low", 64'(dmem_req), 64'(0));
    check("mid_rst:valid_low", 64'(out_valid), 64'(0));
    check("mid_rst:in_ready_low", 64'(in_ready), 64'(0));
    rst_ = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rv:valid", 64'(out_valid), 64'(0));
    check("late_rv:in_ready", 64'(in_ready), 64'(1));
    check("late_rv:rdata", 64'(rdata), 64'(0));
    @(negedge clk);
    check("late_rv:valid2", 64'(out_valid), 64'(0));
    check("late_rv:req", 64'(dmem_req), 64'(0));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
